axi4_slave_ram: RTL and testbench

AXI4 responder (slave) with an internal 128-bit-wide register RAM. It terminates the memory-side port of `axi4_ctrl`, taking the place of the DDR controller in simulation and in FPGA-internal loopback builds. It accepts INCR write bursts and read bursts of 1–16 beats and answers with B and R responses. It supports one outstanding write and one outstanding read, with write and read channels operating independently.

---
 rtl/axi4_slave_ram.sv | 262 ++++++++++++++++++++++++++
 tb/tb_axi4_slave_ram.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_ram.sv
// rtl/axi4_slave_ram.sv - AXI4 responder backed by a 128-bit-wide register RAM
//
// Purpose: terminates an AXI4 memory port with an internal RAM. It handles INCR
// bursts of 1-16 beats, with one outstanding write and one outstanding read.
// The write and read channels run independently of each other.
// Ports:
//   axi_clk, axi_resetn       clock, asynchronous active-low reset
//   axi_aw*  / axi_awready    write address channel (lock/cache/prot/qos ignored)
//   axi_w*   / axi_wready     write data channel
//   axi_b*   / axi_bready     write response channel
//   axi_ar*  / axi_arready    read address channel (lock/cache/prot/qos ignored)
//   axi_r*   / axi_rready     read data channel
module axi4_slave_ram #(
    parameter int MEM_AW     = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic         axi_clk,
    input  logic         axi_resetn,
    input  logic [3:0]   axi_awid,
    input  logic [29:0]  axi_awaddr,
    input  logic [3:0]   axi_awlen,
    input  logic [2:0]   axi_awsize,
    input  logic [1:0]   axi_awburst,
    input  logic         axi_awlock,
    input  logic [3:0]   axi_awcache,
    input  logic [2:0]   axi_awprot,
    input  logic [3:0]   axi_awqos,
    input  logic         axi_awvalid,
    output logic         axi_awready,
    input  logic [127:0] axi_wdata,
    input  logic [15:0]  axi_wstrb,
    input  logic         axi_wlast,
    input  logic         axi_wvalid,
    output logic         axi_wready,
    output logic [3:0]   axi_bid,
    output logic [1:0]   axi_bresp,
    output logic         axi_bvalid,
    input  logic         axi_bready,
    input  logic [3:0]   axi_arid,
    input  logic [29:0]  axi_araddr,
    input  logic [3:0]   axi_arlen,
    input  logic [2:0]   axi_arsize,
    input  logic [1:0]   axi_arburst,
    input  logic         axi_arlock,
    input  logic [3:0]   axi_arcache,
    input  logic [2:0]   axi_arprot,
    input  logic [3:0]   axi_arqos,
    input  logic         axi_arvalid,
    output logic         axi_arready,
    output logic [3:0]   axi_rid,
    output logic [127:0] axi_rdata,
    output logic [1:0]   axi_rresp,
    output logic         axi_rlast,
    output logic         axi_rvalid,
    input  logic         axi_rready
);
    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [MEM_AW-1:0] IDX_ONE = MEM_AW'(1);
    // The wait state lasts RD_LATENCY cycles, so the counter starts one below it.
    localparam logic [3:0] LAT_LOAD = 4'((RD_LATENCY > 0) ? (RD_LATENCY - 1) : 0);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    logic [127:0] mem [DEPTH];

    wstate_t             wstate_q, wstate_d;
    logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [3:0]          bid_q, bid_d, w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [MEM_AW-1:0]   w_idx_q, w_idx_d;
    logic                w_err_q, w_err_d;
    logic                mem_we;

    rstate_t             rstate_q, rstate_d;
    logic                arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [3:0]          rid_q, rid_d, r_len_q, r_len_d, r_cnt_q, r_cnt_d, lat_q, lat_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [127:0]        rdata_q, rdata_d;
    logic [MEM_AW-1:0]   r_idx_q, r_idx_d, r_idx_inc, ar_idx;

    // Ignored sideband and the address bits outside the word index.
    logic unused_ok;
    assign unused_ok = ^{axi_awaddr, axi_araddr, axi_awlock, axi_awcache, axi_awprot,
                         axi_awqos, axi_arlock, axi_arcache, axi_arprot, axi_arqos};

    assign ar_idx    = axi_araddr[MEM_AW+3:4];
    assign r_idx_inc = r_idx_q + IDX_ONE;

    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        case (wstate_q)
            W_IDLE: if (axi_awvalid && awready_q) begin
                bid_d     = axi_awid;
                w_idx_d   = axi_awaddr[MEM_AW+3:4];
                w_len_d   = axi_awlen;
                w_cnt_d   = 4'd0;
                w_err_d   = (axi_awburst != 2'b01) || (axi_awsize != 3'b100);
                awready_d = 1'b0;
                wready_d  = 1'b1;
                wstate_d  = W_DATA;
            end
            W_DATA: if (axi_wvalid && wready_q) begin
                // Data is written even when the burst is flagged as an error.
                mem_we  = 1'b1;
                w_idx_d = w_idx_q + IDX_ONE;
                w_cnt_d = w_cnt_q + 4'd1;
                if (w_cnt_q == w_len_q) begin
                    // A missing wlast on the final beat is an error too.
                    bresp_d  = (w_err_q || !axi_wlast) ? 2'b10 : 2'b00;
                    wready_d = 1'b0;
                    bvalid_d = 1'b1;
                    wstate_d = W_RESP;
                end else if (axi_wlast) begin
                    w_err_d = 1'b1;
                end
            end
            W_RESP: if (axi_bready && bvalid_q) begin
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
                wstate_d  = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // rdata is loaded from the RAM before this cycle's write lands, so a beat
    // read in the same cycle as a write to that word returns the old contents.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        lat_d     = lat_q;
        case (rstate_q)
            R_IDLE: if (axi_arvalid && arready_q) begin
                rid_d     = axi_arid;
                rresp_d   = ((axi_arburst != 2'b01) || (axi_arsize != 3'b100)) ? 2'b10 : 2'b00;
                r_idx_d   = ar_idx;
                r_len_d   = axi_arlen;
                r_cnt_d   = 4'd0;
                arready_d = 1'b0;
                if (RD_LATENCY == 0) begin
                    rvalid_d = 1'b1;
                    rdata_d  = mem[ar_idx];
                    rlast_d  = (axi_arlen == 4'd0);
                    rstate_d = R_DATA;
                end else begin
                    lat_d    = LAT_LOAD;
                    rstate_d = R_WAIT;
                end
            end
            R_WAIT: if (lat_q == 4'd0) begin
                rvalid_d = 1'b1;
                rdata_d  = mem[r_idx_q];
                rlast_d  = (r_len_q == 4'd0);
                rstate_d = R_DATA;
            end else begin
                lat_d = lat_q - 4'd1;
            end
            R_DATA: if (axi_rready && rvalid_q) begin
                if (rlast_q) begin
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end else begin
                    r_idx_d = r_idx_inc;
                    r_cnt_d = r_cnt_q + 4'd1;
                    rdata_d = mem[r_idx_inc];
                    rlast_d = ((r_cnt_q + 4'd1) == r_len_q);
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 4'd0;
            bresp_q   <= 2'b00;
            w_idx_q   <= '0;
            w_len_q   <= 4'd0;
            w_cnt_q   <= 4'd0;
            w_err_q   <= 1'b0;
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 4'd0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            r_idx_q   <= '0;
            r_len_q   <= 4'd0;
            r_cnt_q   <= 4'd0;
            lat_q     <= 4'd0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            lat_q     <= lat_d;
        end
    end

    // RAM has no reset so its contents survive a controller reset.
    always_ff @(posedge axi_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 16; b++) begin
                if (axi_wstrb[b]) mem[w_idx_q][b*8 +: 8] <= axi_wdata[b*8 +: 8];
            end
        end
    end

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bid     = bid_q;
    assign axi_bresp   = bresp_q;
    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rlast   = rlast_q;
    assign axi_rid     = rid_q;
    assign axi_rresp   = rresp_q;
    assign axi_rdata   = rdata_q;
endmodule

// File: tb/tb_axi4_slave_ram.sv
// tb/tb_axi4_slave_ram.sv - directed scoreboard bench for axi4_slave_ram
module tb_axi4_slave_ram;
    localparam int MEM_AW     = 8;
    localparam int RD_LATENCY = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   awid = '0, arid = '0;
    logic [29:0]  awaddr = '0, araddr = '0;
    logic [3:0]   awlen = '0, arlen = '0;
    logic [2:0]   awsize = 3'b100, arsize = 3'b100;
    logic [1:0]   awburst = 2'b01, arburst = 2'b01;
    logic         awvalid = 1'b0, arvalid = 1'b0;
    logic         awready, arready;
    logic [127:0] wdata = '0;
    logic [15:0]  wstrb = '0;
    logic         wlast = 1'b0, wvalid = 1'b0, wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid, bready = 1'b0;
    logic [3:0]   rid;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready = 1'b0;

    axi4_slave_ram #(.MEM_AW(MEM_AW), .RD_LATENCY(RD_LATENCY)) dut (
        .axi_clk(clk), .axi_resetn(rst_n),
        .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
        .axi_awburst(awburst), .axi_awlock(1'b0), .axi_awcache(4'd0), .axi_awprot(3'd0),
        .axi_awqos(4'd0), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid),
        .axi_wready(wready),
        .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize),
        .axi_arburst(arburst), .axi_arlock(1'b0), .axi_arcache(4'd0), .axi_arprot(3'd0),
        .axi_arqos(4'd0), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast),
        .axi_rvalid(rvalid), .axi_rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [127:0] data; logic last; logic [1:0] resp; logic [3:0] id; } rbeat_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [127:0] model [256];
    rbeat_t       rq[$];
    bexp_t        bq[$];
    logic [127:0] wq[$];
    logic [15:0]  sq[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [29:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input int wlast_at, input int bready_delay);
        logic [7:0] idx;
        logic       hs;
        bexp_t      eb;
        idx     = addr[MEM_AW+3:4];
        eb.id   = id;
        eb.resp = ((burst != 2'b01) || (size != 3'b100) || (wlast_at != len)) ? 2'b10 : 2'b00;
        bq.push_back(eb);
        awid = id; awaddr = addr; awlen = 4'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        hs = 1'b0;
        for (int t = 0; t < 50 && !hs; t++) begin hs = awready; tick(); end
        awvalid = 1'b0;
        check("aw_handshake", hs, 1);
        check("aw_awready_low", awready, 0);
        check("aw_wready_high", wready, 1);
        for (int i = 0; i <= len; i++) begin
            wdata = wq[i]; wstrb = sq[i]; wlast = (i == wlast_at); wvalid = 1'b1;
            hs = 1'b0;
            for (int t = 0; t < 50 && !hs; t++) begin hs = wready; tick(); end
            check("w_handshake", hs, 1);
            for (int b = 0; b < 16; b++)
                if (sq[i][b]) model[idx][b*8 +: 8] = wq[i][b*8 +: 8];
            idx = idx + 8'd1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("w_done_wready", wready, 0);
        check("w_done_bvalid", bvalid, 1);
        for (int c = 0; c < bready_delay; c++) begin
            tick();
            check("b_hold", bvalid, 1);
        end
        bready = 1'b1;
        hs = 1'b0;
        for (int t = 0; t < 50 && !hs; t++) begin
            if (bvalid) begin
                hs = 1'b1;
                eb = bq.pop_front();
                check("bid", bid, eb.id);
                check("bresp", bresp, eb.resp);
            end
            tick();
        end
        bready = 1'b0;
        check("b_handshake", hs, 1);
        check("b_awready_back", awready, 1);
        wq.delete();
        sq.delete();
    endtask

    task automatic do_read(input logic [3:0] id, input logic [29:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input bit toggle, input int stop_after);
        logic [7:0]   idx;
        logic         hs, first_seen, held_valid, held_last;
        logic [127:0] held_data;
        rbeat_t       e;
        int           k, got;
        idx = addr[MEM_AW+3:4];
        for (int i = 0; i <= len; i++) begin
            e.data = model[idx];
            e.last = (i == len);
            e.resp = ((burst != 2'b01) || (size != 3'b100)) ? 2'b10 : 2'b00;
            e.id   = id;
            rq.push_back(e);
            idx = idx + 8'd1;
        end
        arid = id; araddr = addr; arlen = 4'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        hs = 1'b0;
        for (int t = 0; t < 50 && !hs; t++) begin hs = arready; tick(); end
        arvalid = 1'b0;
        check("ar_handshake", hs, 1);
        k = 0; got = 0; first_seen = 1'b0; held_valid = 1'b0; held_last = 1'b0; held_data = '0;
        for (int t = 0; t < 300 && rq.size() > 0 && got != stop_after; t++) begin
            rready = toggle ? ((t % 2) == 1) : 1'b1;
            if (rvalid && !first_seen) begin
                first_seen = 1'b1;
                check("r_latency", k, RD_LATENCY);
            end
            if (held_valid) begin
                check("r_hold_valid", rvalid, 1);
                check("r_hold_data", rdata, held_data);
                check("r_hold_last", rlast, held_last);
            end
            held_valid = rvalid && !rready;
            held_data  = rdata;
            held_last  = rlast;
            if (rvalid && rready) begin
                e = rq.pop_front();
                check("rdata", rdata, e.data);
                check("rlast", rlast, e.last);
                check("rresp", rresp, e.resp);
                check("rid", rid, e.id);
                got++;
            end
            tick();
            k++;
        end
        rready = 1'b0;
        if (stop_after < 0) begin
            check("r_complete", rq.size(), 0);
            check("r_arready_back", arready, 1);
        end
    endtask

    initial begin
        repeat (3) tick();
        check("rst_awready", awready, 1);
        check("rst_arready", arready, 1);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_bid_bresp", {bid, bresp}, 0);
        check("rst_rid_rresp", {rid, rresp}, 0);
        check("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        tick();

        // Single-beat write then read back.
        wq.push_back({16{8'h11}}); sq.push_back(16'hFFFF);
        do_write(4'd3, 30'h40, 0, 2'b01, 3'b100, 0, 0);
        do_read(4'd5, 30'h40, 0, 3'b100, 2'b01, 1'b0, -1);

        // 16-beat burst, B held off for 5 cycles, read back with toggling rready.
        for (int i = 0; i < 16; i++) begin wq.push_back(128'(i)); sq.push_back(16'hFFFF); end
        do_write(4'd7, 30'h0, 15, 2'b01, 3'b100, 15, 5);
        do_read(4'd9, 30'h0, 15, 3'b100, 2'b01, 1'b1, -1);

        // Partial strobes on word 32.
        wq.push_back({16{8'hFF}}); sq.push_back(16'hFFFF);
        do_write(4'd1, 30'h200, 0, 2'b01, 3'b100, 0, 0);
        wq.push_back('0); sq.push_back(16'h00FF);
        do_write(4'd1, 30'h200, 0, 2'b01, 3'b100, 0, 0);
        check("strobe_model", model[32], {{8{8'hFF}}, 64'h0});
        do_read(4'd2, 30'h200, 0, 3'b100, 2'b01, 1'b0, -1);

        // Wrap across the top of the RAM, then an aliased read of word 0.
        for (int i = 0; i < 4; i++) begin
            wq.push_back({$urandom, $urandom, $urandom, $urandom}); sq.push_back(16'hFFFF);
        end
        do_write(4'd4, 30'hFE0, 3, 2'b01, 3'b100, 3, 0);
        do_read(4'd4, 30'hFE0, 3, 3'b100, 2'b01, 1'b0, -1);
        do_read(4'd6, 30'h1000, 0, 3'b100, 2'b01, 1'b0, -1);

        // Error responses.
        wq.push_back({4{32'hA5A5_0001}}); sq.push_back(16'hFFFF);
        do_write(4'd8, 30'h300, 0, 2'b10, 3'b100, 0, 0);
        for (int i = 0; i < 4; i++) begin wq.push_back({4{32'hC0DE_0000 + i}}); sq.push_back(16'hFFFF); end
        do_write(4'd10, 30'h400, 3, 2'b01, 3'b100, 1, 0);
        do_read(4'd11, 30'h400, 3, 3'b100, 2'b01, 1'b0, -1);
        do_read(4'd12, 30'h400, 3, 3'b010, 2'b01, 1'b0, -1);

        // Reset while the read is presenting beat 5 of 8.
        do_read(4'd13, 30'h0, 7, 3'b100, 2'b01, 1'b0, 4);
        check("pre_reset_rvalid", rvalid, 1);
        rst_n = 1'b0;
        #1;
        check("reset_rvalid", rvalid, 0);
        check("reset_arready", arready, 1);
        rq.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_arready", arready, 1);
        check("post_reset_rvalid", rvalid, 0);
        do_read(4'd14, 30'h20, 1, 3'b100, 2'b01, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
